// File: rtl/serial_paralelo_idl.sv
// serial_paralelo_idl: serial-to-4-lane deserializer with COMMA alignment and IDL flag
module serial_paralelo_idl #(
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter int         BC_NEEDED = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       IDL
);
  localparam int BW = $clog2(BC_NEEDED + 1);
  localparam logic [BW-1:0] BC_N = BW'(BC_NEEDED);
  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;
  state_t state, state_nxt;
  // seven bits of history; serial_in forms the eighth (newest) bit of the window
  logic [6:0]    sr;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] bc_cnt;
  logic [1:0]    lane_ptr;
  logic [7:0]    st_d [3];
  logic          st_v [3];
  logic [7:0]    w;
  logic          is_comma, done;
  logic [BW-1:0] bc_inc;
  assign w        = {sr, serial_in};
  assign is_comma = (w == COMMA);
  assign done     = (bit_cnt == 3'd7);
  assign bc_inc   = bc_cnt + BW'(1);
  always_comb begin
    state_nxt = state;
    if (state == SEARCH)
      state_nxt = is_comma ? SYNC : SEARCH;
    else if (state == SYNC && done)
      state_nxt = !is_comma ? SEARCH : (bc_inc == BC_N) ? ACTIVE : SYNC;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SEARCH;
    else       state <= state_nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr         <= '0;
      bit_cnt    <= '0;
      bc_cnt     <= '0;
      lane_ptr   <= '0;
      st_d       <= '{default: '0};
      st_v       <= '{default: 1'b0};
      IDL        <= 1'b0;
      data_out0  <= '0;
      data_out1  <= '0;
      data_out2  <= '0;
      data_out3  <= '0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      valid_out2 <= 1'b0;
      valid_out3 <= 1'b0;
    end else begin
      sr      <= w[6:0];
      bit_cnt <= (state == SEARCH) ? 3'd0 : bit_cnt + 3'd1;
      IDL     <= (state_nxt == ACTIVE);
      if (state == SEARCH)
        bc_cnt <= is_comma ? BW'(1) : '0;
      else if (state == SYNC && done)
        bc_cnt <= is_comma ? bc_inc : '0;
      if (state != ACTIVE)
        lane_ptr <= '0;
      else if (done) begin
        lane_ptr <= lane_ptr + 2'd1;
        if (lane_ptr == 2'd3) begin
          data_out0  <= st_d[0];
          data_out1  <= st_d[1];
          data_out2  <= st_d[2];
          data_out3  <= is_comma ? 8'h00 : w;
          valid_out0 <= st_v[0];
          valid_out1 <= st_v[1];
          valid_out2 <= st_v[2];
          valid_out3 <= !is_comma;
        end else begin
          st_d[lane_ptr] <= is_comma ? 8'h00 : w;
          st_v[lane_ptr] <= !is_comma;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_paralelo_idl.sv
// tb_serial_paralelo_idl: directed-vector bench for serial_paralelo_idl
module tb_serial_paralelo_idl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       IDL;
  int n_cmp = 0;
  int n_bad = 0;
  serial_paralelo_idl dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3),
    .IDL(IDL)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // drive the top n bits of b, MSB first; each call returns on a falling edge
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      serial_in = b[i];
      @(negedge clk);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  function automatic logic [31:0] lanes();
    return {data_out0, data_out1, data_out2, data_out3};
  endfunction
  function automatic logic [3:0] valids();
    return {valid_out0, valid_out1, valid_out2, valid_out3};
  endfunction
  initial begin
    repeat (2) @(negedge clk);
    check("rst_idl", {31'b0, IDL}, 32'd0);
    check("rst_data", lanes(), 32'h0);
    check("rst_valid", {28'b0, valids()}, 32'h0);
    reset = 1'b0;
    // four aligned commas, no junk
    repeat (3) send_byte(8'hBC);
    check("idl_after_3bc", {31'b0, IDL}, 32'd0);
    send_bits(8'hBC, 7);
    check("idl_cycle31", {31'b0, IDL}, 32'd0);
    send_bits(8'h00, 1);
    check("idl_cycle32", {31'b0, IDL}, 32'd1);
    check("bc_only_data", lanes(), 32'h0);
    check("bc_only_valid", {28'b0, valids()}, 32'h0);
    repeat (4) send_byte(8'hBC);
    check("comma_group_data", lanes(), 32'h0);
    check("comma_group_valid", {28'b0, valids()}, 32'h0);
    check("comma_group_idl", {31'b0, IDL}, 32'd1);
    // junk bits, commas, then a data group
    pulse_reset();
    send_bits(8'b1010_0000, 3);
    repeat (4) send_byte(8'hBC);
    check("junk_idl", {31'b0, IDL}, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_bits(8'h44, 7);
    check("lanes_hold", lanes(), 32'h0);
    check("valid_hold", {28'b0, valids()}, 32'h0);
    send_bits(8'h00, 1);
    check("grp1_data", lanes(), 32'h11223344);
    check("grp1_valid", {28'b0, valids()}, 32'hF);
    send_byte(8'hAA);
    send_byte(8'hBC);
    send_byte(8'h0F);
    send_byte(8'hBC);
    check("grp2_data", lanes(), 32'hAA000F00);
    check("grp2_valid", {28'b0, valids()}, 32'hA);
    check("grp2_idl", {31'b0, IDL}, 32'd1);
    // asynchronous reset in the middle of a group
    send_byte(8'h77);
    send_byte(8'h88);
    send_bits(8'h99, 3);
    #2 reset = 1'b1;
    #1;
    check("async_idl", {31'b0, IDL}, 32'd0);
    check("async_data", lanes(), 32'h0);
    check("async_valid", {28'b0, valids()}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    check("post_rst_3bc", {31'b0, IDL}, 32'd0);
    send_byte(8'hBC);
    check("post_rst_idl", {31'b0, IDL}, 32'd1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h5A);
    check("post_rst_data", lanes(), 32'h0000005A);
    check("post_rst_valid", {28'b0, valids()}, 32'h1);
    // broken comma run falls back to search
    pulse_reset();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h55);
    check("break_idl", {31'b0, IDL}, 32'd0);
    send_byte(8'hBC);
    check("restart_1bc", {31'b0, IDL}, 32'd0);
    repeat (2) send_byte(8'hBC);
    check("restart_3bc", {31'b0, IDL}, 32'd0);
    send_byte(8'hBC);
    check("restart_4bc", {31'b0, IDL}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
